// File: rtl/pkg_divisor.sv
// Shared definitions for the divider / reconstructor pair: default operand width
// and the reconstructor FSM state encoding.
package pkg_divisor;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        ADD_REM = 2'd2,
        DONE    = 2'd3
    } rec_state_t;

endpackage

// File: rtl/module_contador_indice.sv
// Modulo-N up-counter that walks the quotient bit index; flags the final
// position (N-1) and wraps back to zero on the following enabled step.
module module_contador_indice
    import pkg_divisor::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] cnt,
    output logic          last
);

    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_d;

    assign last = (cnt_q == IW'(N - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/module_reconstructor.sv
// Bit-serial rebuild of the dividend A = Q*B + R: MSB-first shift-add over the
// quotient bits, then one remainder add, with a start/busy/done handshake.
module module_reconstructor
    import pkg_divisor::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   Q,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] A,
    output logic [IW-1:0]  indice
);

    rec_state_t     state_q, state_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   r_q, r_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] a_q, a_d;
    logic           done_q, done_d;

    logic           cnt_clr;
    logic           cnt_en;
    logic           cnt_last;
    logic [IW-1:0]  cnt;
    logic [N-1:0]   q_rev;

    module_contador_indice #(
        .N  (N),
        .IW (IW)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Bit-reversed view so index 0 selects Q[N-1], matching the divider's write order.
    always_comb begin
        q_rev = '0;
        for (int i = 0; i < N; i++) begin
            q_rev[i] = q_q[N-1-i];
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        b_d     = b_q;
        r_d     = r_q;
        acc_d   = acc_q;
        a_d     = a_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = Q;
                    b_d     = B;
                    r_d     = R;
                    acc_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = (acc_q << 1) + (q_rev[cnt] ? {{N{1'b0}}, b_q} : '0);
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ADD_REM;
                end
            end
            ADD_REM: begin
                acc_d   = acc_q + {{N{1'b0}}, r_q};
                state_d = DONE;
            end
            DONE: begin
                a_d     = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            b_q     <= b_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q == MUL) || (state_q == ADD_REM);
    assign done   = done_q;
    assign A      = a_q;
    assign indice = cnt;

endmodule

// File: tb/tb_module_reconstructor.sv
// Directed and round-trip checks for module_reconstructor (N=4): reset state,
// table vectors, handshake timing, start-while-busy and mid-operation reset.
module tb_module_reconstructor;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   Q, B, R;
    logic           busy;
    logic           done;
    logic [2*N-1:0] A;
    logic [1:0]     indice;

    int n_checks = 0;
    int n_pass   = 0;

    module_reconstructor #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .Q      (Q),
        .B      (B),
        .R      (R),
        .busy   (busy),
        .done   (done),
        .A      (A),
        .indice (indice)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic [3:0] b;
        logic [3:0] r;
        int         exp_a;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE and check latency (accept+6) and result.
    task automatic run_op(input logic [3:0] q, input logic [3:0] b,
                          input logic [3:0] r, input int exp_a, input string name);
        int c;
        Q = q; B = b; R = r; start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (c < 20) begin
            tick();
            c++;
            if (done) break;
        end
        check({name, "_latency"}, c, N + 2);
        check({name, "_A"}, int'(A), exp_a);
    endtask

    vec_t vecs[9];

    initial begin
        int done_cnt;
        int a_rt, b_rt;

        vecs[0] = '{4'd3,  4'd4,  4'd1,  13};
        vecs[1] = '{4'd15, 4'd15, 4'd14, 239};
        vecs[2] = '{4'd0,  4'd9,  4'd5,  5};
        vecs[3] = '{4'd8,  4'd0,  4'd0,  0};
        vecs[4] = '{4'd1,  4'd1,  4'd0,  1};
        vecs[5] = '{4'd15, 4'd15, 4'd15, 240};
        vecs[6] = '{4'd10, 4'd3,  4'd2,  32};
        vecs[7] = '{4'd7,  4'd15, 4'd15, 120};
        vecs[8] = '{4'd9,  4'd6,  4'd3,  57};

        rst_n = 1'b0; start = 1'b0; Q = '0; B = '0; R = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_A", int'(A), 0);
        rst_n = 1'b1;

        // Idle after reset with no start.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", int'({busy, done, A, indice}), 0);
        end

        // Hand sequence: indice stepping and busy window for Q=3,B=4,R=1.
        Q = 4'd3; B = 4'd4; R = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mul_indice", int'(indice), i);
            check("mul_busy", int'(busy), 1);
            tick();
        end
        check("addrem_busy", int'(busy), 1);
        check("addrem_done", int'(done), 0);
        tick();
        check("donestate_busy", int'(busy), 0);
        check("donestate_done", int'(done), 0);
        tick();
        check("seq_done", int'(done), 1);
        check("seq_A", int'(A), 13);
        check("seq_indice_wrap", int'(indice), 0);
        tick();
        check("done_pulse_width", int'(done), 0);
        check("A_held", int'(A), 13);

        // Table vectors, launched back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].exp_a, $sformatf("vec%0d", i));
        end

        // start held high and operands scrambled while busy.
        tick();
        Q = 4'd3; B = 4'd5; R = 4'd2; start = 1'b1;
        tick();
        done_cnt = 0;
        for (int i = 0; i < 20 && done_cnt == 0; i++) begin
            Q = 4'($urandom); B = 4'($urandom); R = 4'($urandom);
            tick();
            check("busy_done_excl", int'(busy & done), 0);
            if (done) begin
                done_cnt++;
                start = 1'b0;
            end
        end
        check("held_start_A", int'(A), 17);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("held_start_done_count", done_cnt, 1);
        check("held_start_A_stable", int'(A), 17);

        // Reset in the middle of MUL (indice==2).
        Q = 4'd15; B = 4'd15; R = 4'd14; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_abort_indice", int'(indice), 2);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", int'({busy, done, A, indice}), 0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_op(4'd6, 4'd7, 4'd5, 47, "after_abort");

        // Round trip with divider-style outputs (quotient must fit in N bits).
        for (int i = 0; i < 1000; i++) begin
            b_rt = $urandom_range(1, 15);
            a_rt = $urandom_range(0, 16 * b_rt - 1);
            run_op(4'(a_rt / b_rt), 4'(b_rt), 4'(a_rt % b_rt), a_rt, "roundtrip");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
